// File: rtl/usb_fs_bus_pkg.sv
// ---------------------------------------------------------------------------
// usb_fs_bus_pkg
// Shared types and default timing for the USB full-speed bus controller.
//   bus_state_e  : sequencer states (DETACH, IDLE, PKT, RESUME)
//   line_state_e : received line encoding as {dp, dn}
//   DEF_*_CYCLES : default timing at 48 MHz
// No ports. The RESUME state is only used by the controller when
// USB_FS_BUS_CTRL_RESUME_EN is defined.
// ---------------------------------------------------------------------------
package usb_fs_bus_pkg;

  typedef enum logic [1:0] {
    DETACH = 2'd0,
    IDLE   = 2'd1,
    PKT    = 2'd2,
    RESUME = 2'd3
  } bus_state_e;

  // Line states packed as {dp, dn}; J is the full-speed idle state.
  typedef enum logic [1:0] {
    LINE_SE0 = 2'b00,
    LINE_K   = 2'b01,
    LINE_J   = 2'b10,
    LINE_SE1 = 2'b11
  } line_state_e;

  localparam int DEF_DETACH_CYCLES  = 160000;
  localparam int DEF_RESET_CYCLES   = 30000;
  localparam int DEF_SUSPEND_CYCLES = 144000;
  localparam int DEF_RESUME_CYCLES  = 96000;

endpackage

// File: rtl/usb_fs_line_monitor.sv
// ---------------------------------------------------------------------------
// usb_fs_line_monitor
// Watches the received line for host bus reset (long SE0) and suspend
// (long J). Both counters saturate and clear on any other line state.
// Ports:
//   i_clk, i_reset_n   : clock, asynchronous active-low reset
//   i_dp_rx, i_dn_rx   : synchronised received line
//   i_enable           : monitoring allowed (attached and not driving)
//   i_clear            : clear counters and both flags (detach)
//   i_susp_clr         : force suspended low (resume finished, transmitting)
//   o_bus_reset        : se0 count at its limit
//   o_suspended        : j count reached its limit, held until activity
// ---------------------------------------------------------------------------
module usb_fs_line_monitor
  import usb_fs_bus_pkg::*;
#(
  parameter int RESET_CYCLES   = DEF_RESET_CYCLES,
  parameter int SUSPEND_CYCLES = DEF_SUSPEND_CYCLES
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_dp_rx,
  input  logic i_dn_rx,
  input  logic i_enable,
  input  logic i_clear,
  input  logic i_susp_clr,
  output logic o_bus_reset,
  output logic o_suspended
);

  localparam int SW = $clog2(RESET_CYCLES + 1);
  localparam int JW = $clog2(SUSPEND_CYCLES + 1);
  localparam logic [SW-1:0] SE0_MAX = SW'(RESET_CYCLES);
  localparam logic [JW-1:0] J_MAX   = JW'(SUSPEND_CYCLES);

  line_state_e   w_line;
  logic          w_is_se0;
  logic          w_is_j;
  logic [SW-1:0] r_se0_cnt;
  logic [SW-1:0] w_se0_next;
  logic [JW-1:0] r_j_cnt;
  logic [JW-1:0] w_j_next;
  logic          r_bus_reset;
  logic          r_suspended;

  assign w_line   = line_state_e'({i_dp_rx, i_dn_rx});
  assign w_is_se0 = (w_line == LINE_SE0);
  assign w_is_j   = (w_line == LINE_J);

  // Next counter values. Anything other than the matching line state
  // (including SE1) drops a counter back to zero, and the counters are
  // held at zero whenever monitoring is disabled.
  always_comb begin
    w_se0_next = '0;
    w_j_next   = '0;
    if (i_enable && !i_clear) begin
      if (w_is_se0) begin
        w_se0_next = (r_se0_cnt == SE0_MAX) ? SE0_MAX : r_se0_cnt + SW'(1);
      end
      if (w_is_j) begin
        w_j_next = (r_j_cnt == J_MAX) ? J_MAX : r_j_cnt + JW'(1);
      end
    end
  end

  // Flags are registered from the next counter values so they change on
  // the same edge the counter reaches its limit. Suspended is sticky
  // across periods where monitoring is off (e.g. while resume K is being
  // driven) and only drops on real activity or an explicit clear.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_se0_cnt   <= '0;
      r_j_cnt     <= '0;
      r_bus_reset <= 1'b0;
      r_suspended <= 1'b0;
    end else begin
      r_se0_cnt   <= w_se0_next;
      r_j_cnt     <= w_j_next;
      r_bus_reset <= (w_se0_next == SE0_MAX);
      if (i_clear || i_susp_clr) begin
        r_suspended <= 1'b0;
      end else if (i_enable) begin
        r_suspended <= (w_j_next == J_MAX) || (r_suspended && w_is_j);
      end
    end
  end

  assign o_bus_reset = r_bus_reset;
  assign o_suspended = r_suspended;

endmodule

// File: rtl/usb_fs_bus_ctrl.sv
// ---------------------------------------------------------------------------
// usb_fs_bus_ctrl
// Sequencer/arbiter in front of the USB full-speed line mux. Owns the
// mux oe/dp_tx/dn_tx and the pull-up, sequences attach/detach, shares the
// transmit path between the packet transmitter and remote wakeup, and
// reports bus reset / suspend from the received line.
// Optional feature macro: USB_FS_BUS_CTRL_RESUME_EN enables the RESUME
// state and wake_req handling; without it wake_req is ignored and
// wake_busy stays 0.
// Ports:
//   i_clk, i_reset_n                 : 48 MHz clock, async active-low reset
//   i_dp_rx, i_dn_rx                 : synchronised received line
//   i_detach_req                     : level, soft detach
//   i_pkt_req/oe/dp/dn, o_pkt_gnt    : packet transmitter request and drive
//   i_wake_req, o_wake_busy          : remote-wakeup request / K in progress
//   o_oe, o_dp_tx, o_dn_tx, o_pu     : mux drive and pull-up
//   o_attached                       : pull-up on, device visible
//   o_bus_reset, o_suspended         : line monitor status
// ---------------------------------------------------------------------------
module usb_fs_bus_ctrl
  import usb_fs_bus_pkg::*;
#(
  parameter int DETACH_CYCLES  = DEF_DETACH_CYCLES,
  parameter int RESET_CYCLES   = DEF_RESET_CYCLES,
  parameter int SUSPEND_CYCLES = DEF_SUSPEND_CYCLES,
  parameter int RESUME_CYCLES  = DEF_RESUME_CYCLES
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_dp_rx,
  input  logic i_dn_rx,
  input  logic i_detach_req,
  input  logic i_pkt_req,
  input  logic i_pkt_oe,
  input  logic i_pkt_dp,
  input  logic i_pkt_dn,
  output logic o_pkt_gnt,
  input  logic i_wake_req,
  output logic o_wake_busy,
  output logic o_oe,
  output logic o_dp_tx,
  output logic o_dn_tx,
  output logic o_pu,
  output logic o_attached,
  output logic o_bus_reset,
  output logic o_suspended
);

  // One shared timer serves both the detach SE0 and the resume K.
  localparam int TIMER_MAX = (DETACH_CYCLES > RESUME_CYCLES) ? DETACH_CYCLES : RESUME_CYCLES;
  localparam int TW = $clog2(TIMER_MAX + 1);
  localparam logic [TW-1:0] DETACH_LAST = TW'(DETACH_CYCLES - 1);

  bus_state_e    r_state;
  logic [TW-1:0] r_timer;
  logic          r_oe;
  logic          r_dp;
  logic          r_dn;
  logic          r_pu;
  logic          r_attached;
  logic          r_pkt_gnt;
  logic          r_wake_busy;
  logic          w_bus_reset;
  logic          w_suspended;
  logic          w_resume_done;
  logic          w_mon_enable;
  logic          w_mon_clear;
  logic          w_susp_clr;

`ifdef USB_FS_BUS_CTRL_RESUME_EN
  localparam logic [TW-1:0] RESUME_LAST = TW'(RESUME_CYCLES - 1);
  assign w_resume_done = (r_state == RESUME) && (r_timer == RESUME_LAST);
`else
  logic w_unused_wake;
  assign w_unused_wake = i_wake_req;
  assign w_resume_done = 1'b0;
`endif

  // The monitor only listens while the pull-up is on and nothing drives
  // the line. Transmitting counts as bus activity, so it also ends suspend.
  assign w_mon_enable = r_attached && !r_oe;
  assign w_mon_clear  = i_detach_req || (r_state == DETACH);
  assign w_susp_clr   = w_resume_done || (r_state == PKT);

  usb_fs_line_monitor #(
    .RESET_CYCLES  (RESET_CYCLES),
    .SUSPEND_CYCLES(SUSPEND_CYCLES)
  ) u_line_monitor (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_dp_rx    (i_dp_rx),
    .i_dn_rx    (i_dn_rx),
    .i_enable   (w_mon_enable),
    .i_clear    (w_mon_clear),
    .i_susp_clr (w_susp_clr),
    .o_bus_reset(w_bus_reset),
    .o_suspended(w_suspended)
  );

  // Main sequencer. Every pin is a register set here, so a decision shows
  // up on the pins one cycle later. Detach overrides everything and holds
  // the timer at zero so the full SE0 period starts once it is released.
  // In IDLE the packet request is checked first, so a simultaneous wake
  // request is simply lost.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= DETACH;
      r_timer     <= '0;
      r_oe        <= 1'b1;
      r_dp        <= 1'b0;
      r_dn        <= 1'b0;
      r_pu        <= 1'b0;
      r_attached  <= 1'b0;
      r_pkt_gnt   <= 1'b0;
      r_wake_busy <= 1'b0;
    end else if (i_detach_req) begin
      r_state     <= DETACH;
      r_timer     <= '0;
      r_oe        <= 1'b1;
      r_dp        <= 1'b0;
      r_dn        <= 1'b0;
      r_pu        <= 1'b0;
      r_attached  <= 1'b0;
      r_pkt_gnt   <= 1'b0;
      r_wake_busy <= 1'b0;
    end else begin
      case (r_state)
        DETACH: begin
          if (r_timer == DETACH_LAST) begin
            r_state    <= IDLE;
            r_timer    <= '0;
            r_oe       <= 1'b0;
            r_pu       <= 1'b1;
            r_attached <= 1'b1;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        IDLE: begin
          r_oe <= 1'b0;
          r_dp <= 1'b0;
          r_dn <= 1'b0;
          if (i_pkt_req && !w_bus_reset) begin
            r_state   <= PKT;
            r_pkt_gnt <= 1'b1;
          end
`ifdef USB_FS_BUS_CTRL_RESUME_EN
          else if (i_wake_req && w_suspended) begin
            r_state     <= RESUME;
            r_timer     <= '0;
            r_oe        <= 1'b1;
            r_dp        <= 1'b0;
            r_dn        <= 1'b1;
            r_wake_busy <= 1'b1;
          end
`endif
        end
        PKT: begin
          if (i_pkt_req) begin
            r_oe <= i_pkt_oe;
            r_dp <= i_pkt_dp;
            r_dn <= i_pkt_dn;
          end else begin
            r_state   <= IDLE;
            r_pkt_gnt <= 1'b0;
            r_oe      <= 1'b0;
            r_dp      <= 1'b0;
            r_dn      <= 1'b0;
          end
        end
`ifdef USB_FS_BUS_CTRL_RESUME_EN
        RESUME: begin
          if (w_resume_done) begin
            r_state     <= IDLE;
            r_timer     <= '0;
            r_oe        <= 1'b0;
            r_dn        <= 1'b0;
            r_wake_busy <= 1'b0;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
`endif
        default: begin
          r_state <= DETACH;
          r_timer <= '0;
          r_oe    <= 1'b1;
          r_dp    <= 1'b0;
          r_dn    <= 1'b0;
        end
      endcase
    end
  end

  assign o_pkt_gnt   = r_pkt_gnt;
  assign o_wake_busy = r_wake_busy;
  assign o_oe        = r_oe;
  assign o_dp_tx     = r_dp;
  assign o_dn_tx     = r_dn;
  assign o_pu        = r_pu;
  assign o_attached  = r_attached;
  assign o_bus_reset = w_bus_reset;
  assign o_suspended = w_suspended;

endmodule
